// File: rtl/mem_access_unit.sv
// Load/store unit behind EX: runs one memory request at a time on a req/ack bus,
// builds strobes and lane-shifted store data, and extends load data for writeback.
module mem_access_unit #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd_en_i,
  input  logic              mem_wr_en_i,
  input  logic [ADDR_W-1:0] addr_mem_i,
  input  logic [DATA_W-1:0] data_mem_wr_i,
  input  logic [2:0]        load_code_i,
  input  logic [1:0]        store_code_i,
  input  logic [4:0]        addr_reg_wr_i,
  output logic              hold_req_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [7:0]        bus_wstrb_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              load_vld_o,
  output logic [4:0]        load_addr_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              misalign_o,
  output logic              bus_err_o
);

  localparam int CNT_W = 16;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

  state_t            state_r, state_s;
  logic              access_s, is_store_s, aligned_s;
  logic [1:0]        size_s;
  logic [2:0]        off_s;
  logic [7:0]        wstrb_s;
  logic [DATA_W-1:0] wdata_s;
  logic              issue_s, misalign_s, done_s, abort_s, hold_s, timeout_hit_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              is_load_r;
  logic [2:0]        load_code_r, off_r;
  logic [4:0]        rd_r;
  logic [DATA_W-1:0] tmp_s, load_ext_s;

  logic              bus_req_r, bus_we_r, load_vld_r, misalign_r, bus_err_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r, load_data_r;
  logic [7:0]        bus_wstrb_r;
  logic [4:0]        load_addr_r;

  // Decode the EX request: access size, alignment, strobes and shifted store data
  always_comb begin
    access_s   = mem_rd_en_i | mem_wr_en_i;
    is_store_s = mem_wr_en_i;
    off_s      = addr_mem_i[2:0];
    if (is_store_s) begin
      size_s = store_code_i;
    end else if (load_code_i == 3'b111) begin
      size_s = 2'b11;
    end else begin
      size_s = load_code_i[1:0];
    end
    case (size_s)
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~off_s[0];
      2'b10:   aligned_s = (off_s[1:0] == 2'b00);
      2'b11:   aligned_s = (off_s == 3'b000);
      default: aligned_s = 1'b0;
    endcase
    case (store_code_i)
      2'b00:   wstrb_s = 8'h01 << off_s;
      2'b01:   wstrb_s = 8'h03 << off_s;
      2'b10:   wstrb_s = 8'h0F << off_s;
      2'b11:   wstrb_s = 8'hFF;
      default: wstrb_s = 8'h00;
    endcase
    wdata_s = data_mem_wr_i << {off_s, 3'b000};
  end

  // Shift the returned word down to the accessed lane and extend it
  always_comb begin
    tmp_s = bus_rdata_i >> {off_r, 3'b000};
    case (load_code_r)
      3'b000:  load_ext_s = {{56{tmp_s[7]}}, tmp_s[7:0]};
      3'b001:  load_ext_s = {{48{tmp_s[15]}}, tmp_s[15:0]};
      3'b010:  load_ext_s = {{32{tmp_s[31]}}, tmp_s[31:0]};
      3'b100:  load_ext_s = {56'd0, tmp_s[7:0]};
      3'b101:  load_ext_s = {48'd0, tmp_s[15:0]};
      3'b110:  load_ext_s = {32'd0, tmp_s[31:0]};
      default: load_ext_s = tmp_s;
    endcase
  end

  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_r == CNT_W'(TIMEOUT - 1));

  // Next-state and control decode; ack takes priority over a same-cycle timeout
  always_comb begin
    state_s    = state_r;
    hold_s     = 1'b0;
    issue_s    = 1'b0;
    misalign_s = 1'b0;
    done_s     = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s && aligned_s) begin
          issue_s = 1'b1;
          hold_s  = 1'b1;
          state_s = ST_BUS;
        end else if (access_s) begin
          misalign_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        hold_s = ~bus_ack_i & ~timeout_hit_s;
        if (bus_ack_i) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          abort_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BUS;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and wait counter; counter only runs while staying in BUS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == ST_BUS && state_s == ST_BUS) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  // Bus drive, latched request context and one-cycle result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_wdata_r <= {DATA_W{1'b0}};
      bus_wstrb_r <= 8'h00;
      is_load_r   <= 1'b0;
      load_code_r <= 3'b000;
      off_r       <= 3'b000;
      rd_r        <= 5'd0;
      load_vld_r  <= 1'b0;
      load_addr_r <= 5'd0;
      load_data_r <= {DATA_W{1'b0}};
      misalign_r  <= 1'b0;
      bus_err_r   <= 1'b0;
    end else begin
      misalign_r <= misalign_s;
      bus_err_r  <= abort_s;
      load_vld_r <= done_s & is_load_r;
      if (issue_s) begin
        bus_req_r   <= 1'b1;
        bus_we_r    <= is_store_s;
        bus_addr_r  <= {addr_mem_i[ADDR_W-1:3], 3'b000};
        bus_wdata_r <= is_store_s ? wdata_s : {DATA_W{1'b0}};
        bus_wstrb_r <= is_store_s ? wstrb_s : 8'h00;
        is_load_r   <= ~is_store_s;
        load_code_r <= load_code_i;
        off_r       <= off_s;
        rd_r        <= addr_reg_wr_i;
      end else if (done_s || abort_s) begin
        bus_req_r <= 1'b0;
      end
      if (done_s && is_load_r) begin
        load_addr_r <= rd_r;
        load_data_r <= load_ext_s;
      end
    end
  end

  assign hold_req_o  = hold_s;
  assign bus_req_o   = bus_req_r;
  assign bus_we_o    = bus_we_r;
  assign bus_addr_o  = bus_addr_r;
  assign bus_wdata_o = bus_wdata_r;
  assign bus_wstrb_o = bus_wstrb_r;
  assign load_vld_o  = load_vld_r;
  assign load_addr_o = load_addr_r;
  assign load_data_o = load_data_r;
  assign misalign_o  = misalign_r;
  assign bus_err_o   = bus_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; load results are checked through a scoreboard queue.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd_en_i, mem_wr_en_i;
  logic [63:0] addr_mem_i, data_mem_wr_i;
  logic [2:0]  load_code_i;
  logic [1:0]  store_code_i;
  logic [4:0]  addr_reg_wr_i;
  logic        hold_req_o, bus_req_o, bus_we_o;
  logic [63:0] bus_addr_o, bus_wdata_o;
  logic [7:0]  bus_wstrb_o;
  logic        bus_ack_i;
  logic [63:0] bus_rdata_i;
  logic        load_vld_o;
  logic [4:0]  load_addr_o;
  logic [63:0] load_data_o;
  logic        misalign_o, bus_err_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [68:0] exp_q[$];
  logic [68:0] exp_item;
  int hold_cnt, req_cnt, err_cnt;

  mem_access_unit #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .addr_mem_i(addr_mem_i), .data_mem_wr_i(data_mem_wr_i),
    .load_code_i(load_code_i), .store_code_i(store_code_i),
    .addr_reg_wr_i(addr_reg_wr_i), .hold_req_o(hold_req_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .load_vld_o(load_vld_o), .load_addr_o(load_addr_o), .load_data_o(load_data_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every load result popped against what the stimulus pushed
  always @(negedge clk) begin
    if (rst_n === 1'b1 && load_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("load_unexpected", 64'(load_vld_o), 64'd0);
      end else begin
        exp_item = exp_q.pop_front();
        chk("load_addr", 64'(load_addr_o), 64'(exp_item[68:64]));
        chk("load_data", load_data_o, exp_item[63:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; mem_rd_en_i = 1'b0; mem_wr_en_i = 1'b0;
    addr_mem_i = 64'd0; data_mem_wr_i = 64'd0; load_code_i = 3'd0;
    store_code_i = 2'd0; addr_reg_wr_i = 5'd0; bus_ack_i = 1'b0; bus_rdata_i = 64'd0;
    repeat (3) tick();
    chk("rst_req", 64'(bus_req_o), 64'd0);
    chk("rst_hold", 64'(hold_req_o), 64'd0);
    chk("rst_misc", 64'({bus_we_o, bus_wstrb_o, load_vld_o, misalign_o, bus_err_o}), 64'd0);
    chk("rst_addr", bus_addr_o, 64'd0);
    rst_n = 1'b1;

    // 1: LW 0x1004, ack on the 4th bus cycle (coincides with the timeout slot)
    tick();
    mem_rd_en_i = 1'b1; addr_mem_i = 64'h1004; load_code_i = 3'b010; addr_reg_wr_i = 5'd5;
    exp_q.push_back({5'd5, 64'hFFFF_FFFF_8000_0001});
    #1; hold_cnt = int'(hold_req_o);
    chk("t1_req_before", 64'(bus_req_o), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      mem_rd_en_i = 1'b0; bus_ack_i = (i == 4); bus_rdata_i = 64'h8000_0001_1234_5678;
      #1; hold_cnt += int'(hold_req_o);
      if (i == 1) begin
        chk("t1_req", 64'(bus_req_o), 64'd1);
        chk("t1_we", 64'(bus_we_o), 64'd0);
        chk("t1_addr", bus_addr_o, 64'h1000);
        chk("t1_wstrb", 64'(bus_wstrb_o), 64'd0);
      end
    end
    chk("t1_hold_cycles", 64'(hold_cnt), 64'd4);
    tick(); bus_ack_i = 1'b0; #1;
    chk("t1_req_drop", 64'(bus_req_o), 64'd0);
    chk("t1_vld", 64'(load_vld_o), 64'd1);

    // 2: SB 0x2003, ack on 2nd bus cycle
    tick();
    mem_wr_en_i = 1'b1; addr_mem_i = 64'h2003; store_code_i = 2'b00; data_mem_wr_i = 64'hAB;
    #1; hold_cnt = int'(hold_req_o);
    for (int i = 1; i <= 2; i++) begin
      tick();
      mem_wr_en_i = 1'b0; bus_ack_i = (i == 2);
      #1; hold_cnt += int'(hold_req_o);
      if (i == 1) begin
        chk("t2_we", 64'(bus_we_o), 64'd1);
        chk("t2_wstrb", 64'(bus_wstrb_o), 64'h08);
        chk("t2_wdata", bus_wdata_o, 64'h0000_0000_AB00_0000);
        chk("t2_addr", bus_addr_o, 64'h2000);
      end
    end
    chk("t2_hold_cycles", 64'(hold_cnt), 64'd2);
    tick(); bus_ack_i = 1'b0; #1;
    chk("t2_req_drop", 64'(bus_req_o), 64'd0);

    // 3: misaligned LH 0x3001
    tick();
    mem_rd_en_i = 1'b1; addr_mem_i = 64'h3001; load_code_i = 3'b001; addr_reg_wr_i = 5'd6;
    #1; chk("t3_hold", 64'(hold_req_o), 64'd0);
    tick(); mem_rd_en_i = 1'b0; #1;
    chk("t3_misalign", 64'(misalign_o), 64'd1);
    chk("t3_req", 64'(bus_req_o), 64'd0);
    tick(); #1;
    chk("t3_misalign_pulse", 64'(misalign_o), 64'd0);
    chk("t3_req_after", 64'(bus_req_o), 64'd0);

    // 4: LD with no ack, TIMEOUT=4
    tick();
    mem_rd_en_i = 1'b1; addr_mem_i = 64'h6000; load_code_i = 3'b011; addr_reg_wr_i = 5'd7;
    #1; hold_cnt = int'(hold_req_o); req_cnt = 0; err_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(); mem_rd_en_i = 1'b0; #1;
      hold_cnt += int'(hold_req_o);
      req_cnt  += int'(bus_req_o);
      err_cnt  += int'(bus_err_o);
      if (bus_err_o) chk("t4_err_slot", 64'(i), 64'd5);
    end
    chk("t4_req_cycles", 64'(req_cnt), 64'd4);
    chk("t4_err_pulses", 64'(err_cnt), 64'd1);
    chk("t4_hold_cycles", 64'(hold_cnt), 64'd4);

    // 5: rd and wr together, SD 0x4000: store wins
    tick();
    mem_rd_en_i = 1'b1; mem_wr_en_i = 1'b1; addr_mem_i = 64'h4000; load_code_i = 3'b011;
    store_code_i = 2'b11; data_mem_wr_i = 64'h0123_4567_89AB_CDEF; addr_reg_wr_i = 5'd9;
    #1; chk("t5_hold", 64'(hold_req_o), 64'd1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      mem_rd_en_i = 1'b0; mem_wr_en_i = 1'b0; bus_ack_i = (i == 2);
      #1;
      if (i == 1) begin
        chk("t5_we", 64'(bus_we_o), 64'd1);
        chk("t5_wstrb", 64'(bus_wstrb_o), 64'hFF);
        chk("t5_wdata", bus_wdata_o, 64'h0123_4567_89AB_CDEF);
      end
    end
    tick(); bus_ack_i = 1'b0; #1;
    chk("t5_vld", 64'(load_vld_o), 64'd0);

    // 6: reset in the 2nd bus wait cycle, then LBU 0x5007
    tick();
    mem_rd_en_i = 1'b1; addr_mem_i = 64'h1000; load_code_i = 3'b010; addr_reg_wr_i = 5'd3;
    tick(); mem_rd_en_i = 1'b0;
    tick(); #1;
    chk("t6_req_before_rst", 64'(bus_req_o), 64'd1);
    rst_n = 1'b0; #1;
    chk("t6_req_async", 64'(bus_req_o), 64'd0);
    chk("t6_hold_rst", 64'(hold_req_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    mem_rd_en_i = 1'b1; addr_mem_i = 64'h5007; load_code_i = 3'b100; addr_reg_wr_i = 5'd11;
    exp_q.push_back({5'd11, 64'h0000_0000_0000_009C});
    #1; chk("t6_idle_issue", 64'(hold_req_o), 64'd1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      mem_rd_en_i = 1'b0; bus_ack_i = (i == 2); bus_rdata_i = 64'h9C11_2233_4455_6677;
      #1;
      if (i == 1) chk("t6_addr", bus_addr_o, 64'h5000);
    end
    tick(); bus_ack_i = 1'b0; #1;
    chk("t6_vld", 64'(load_vld_o), 64'd1);

    repeat (3) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
